// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: CHANNELS divided clocks plus rising-edge ticks from clksrc.
// Optional CLOCK_DIV_SYNC_EN adds sync_in, which forces every running channel to wrap on the same edge.
module clock_div_multi #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 16,
    parameter int FREQ_INPUT  = 500_000,
    parameter int FREQ_OUTPUT = 100_000,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clksrc,
    input  logic                rstn,
`ifdef CLOCK_DIV_SYNC_EN
    input  logic                sync_in,
`endif
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] cfg_pend,
    output logic [CHANNELS-1:0] clkout,
    output logic [CHANNELS-1:0] tick
);

    localparam int DEFAULT_DIV = FREQ_INPUT / FREQ_OUTPUT;
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("clock_div_multi: CHANNELS must be within 1..16");
    end
    if (DEFAULT_DIV < 1 || DEFAULT_DIV > (2**DIV_W) - 1) begin : g_bad_default
        $error("clock_div_multi: FREQ_INPUT/FREQ_OUTPUT does not fit 1..2^DIV_W-1");
    end

    logic wr_ok;
    logic sync_go;

    assign wr_ok = cfg_wr && (cfg_div != '0) && ({1'b0, cfg_ch} < CH_LIMIT);

`ifdef CLOCK_DIV_SYNC_EN
    assign sync_go = sync_in;
`else
    assign sync_go = 1'b0;
`endif

    always_ff @(posedge clksrc or negedge rstn) begin
        if (!rstn) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !wr_ok;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DIV_W-1:0] div_act;
        logic [DIV_W-1:0] div_pend;
        logic             pend;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] cnt_nx;
        logic [DIV_W-1:0] high;
        logic             clk_q;
        logic             tick_q;
        logic             wrap;
        logic             wr_hit;

        assign cnt_nx = cnt + ONE;
        assign high   = div_act - (div_act >> 1);
        assign wrap   = (cnt == div_act - ONE);
        assign wr_hit = wr_ok && (cfg_ch == CH_W'(i));

        // The write capture comes last so a write on a wrap or idle-apply edge
        // survives into div_pend while the apply itself uses the old values.
        always_ff @(posedge clksrc or negedge rstn) begin
            if (!rstn) begin
                div_act  <= DEF_DIV;
                div_pend <= DEF_DIV;
                pend     <= 1'b0;
                cnt      <= DEF_DIV - ONE;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                if (!en[i]) begin
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend) begin
                        div_act <= div_pend;
                        cnt     <= div_pend - ONE;
                        pend    <= 1'b0;
                    end else begin
                        cnt <= div_act - ONE;
                    end
                end else if (wrap || sync_go) begin
                    if (pend) begin
                        div_act <= div_pend;
                        pend    <= 1'b0;
                    end
                    cnt    <= '0;
                    clk_q  <= 1'b1;
                    tick_q <= 1'b1;
                end else begin
                    cnt    <= cnt_nx;
                    clk_q  <= (cnt_nx < high);
                    tick_q <= 1'b0;
                end
                if (wr_hit) begin
                    div_pend <= cfg_div;
                    pend     <= 1'b1;
                end
            end
        end

        assign clkout[i]   = clk_q;
        assign tick[i]     = tick_q;
        assign cfg_pend[i] = pend;
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi: the driver queues hand-computed per-cycle outputs, a monitor pops and compares.
// A second 3-channel instance exercises the out-of-range channel rejection.
module tb_clock_div_multi;

    localparam int W = 17;

    logic        clksrc = 1'b0;
    logic        rstn;
    logic [3:0]  en;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_err;
    logic [3:0]  cfg_pend;
    logic [3:0]  clkout;
    logic [3:0]  tick;
`ifdef CLOCK_DIV_SYNC_EN
    logic        sync_in;
`endif

    logic [2:0]  en3;
    logic        cfg_wr3;
    logic        err3;
    logic [2:0]  pend3;
    logic [2:0]  clk3;
    logic [2:0]  tick3;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    event         sample_now;

    always #5 clksrc = ~clksrc;

    clock_div_multi #(.CHANNELS(4), .DIV_W(16), .FREQ_INPUT(500_000), .FREQ_OUTPUT(100_000)) dut (
        .clksrc   (clksrc),
        .rstn     (rstn),
`ifdef CLOCK_DIV_SYNC_EN
        .sync_in  (sync_in),
`endif
        .en       (en),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_err  (cfg_err),
        .cfg_pend (cfg_pend),
        .clkout   (clkout),
        .tick     (tick)
    );

    clock_div_multi #(.CHANNELS(3), .DIV_W(16), .FREQ_INPUT(500_000), .FREQ_OUTPUT(100_000)) dut3 (
        .clksrc   (clksrc),
        .rstn     (rstn),
`ifdef CLOCK_DIV_SYNC_EN
        .sync_in  (1'b0),
`endif
        .en       (en3),
        .cfg_wr   (cfg_wr3),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_err  (err3),
        .cfg_pend (pend3),
        .clkout   (clk3),
        .tick     (tick3)
    );

    // Monitor: compares on every falling edge, or immediately when the driver fires sample_now.
    initial begin : monitor
        logic [W-1:0] x;
        logic [W-1:0] g;
        string        nm;
        forever begin
            @(negedge clksrc or sample_now);
            if (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                g  = {err3, pend3, cfg_err, cfg_pend, tick, clkout};
                n_vec++;
                if (g !== x) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got err3=%b pend3=%b err=%b pend=%b tick=%b clk=%b, expected err3=%b pend3=%b err=%b pend=%b tick=%b clk=%b",
                             nm, $time, g[16], g[15:13], g[12], g[11:8], g[7:4], g[3:0],
                             x[16], x[15:13], x[12], x[11:8], x[7:4], x[3:0]);
                end
            end
        end
    end

    task automatic cyc(input logic [3:0] e, input logic wr, input logic [1:0] ch, input logic [15:0] dv,
                       input logic x_err, input logic [3:0] x_pend, input logic [3:0] x_tick,
                       input logic [3:0] x_clk, input string nm,
                       input logic wr3 = 1'b0, input logic x_err3 = 1'b0);
        en      = e;
        cfg_wr  = wr;
        cfg_ch  = ch;
        cfg_div = dv;
        cfg_wr3 = wr3;
        @(posedge clksrc);
        #1;
        exp_q.push_back({x_err3, 3'b000, x_err, x_pend, x_tick, x_clk});
        name_q.push_back(nm);
    endtask

    // Asserts reset between edges and checks the outputs before any further clock edge.
    task automatic rst_now();
        @(negedge clksrc);
        #1;
        rstn = 1'b0;
        exp_q.push_back('0);
        name_q.push_back("async_reset");
        #1;
        -> sample_now;
    endtask

    initial begin : driver
        rstn    = 1'b0;
        en      = '0;
        en3     = '0;
        cfg_wr  = 1'b0;
        cfg_wr3 = 1'b0;
        cfg_ch  = '0;
        cfg_div = '0;
`ifdef CLOCK_DIV_SYNC_EN
        sync_in = 1'b0;
`endif

        cyc(4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, "reset");
        cyc(4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, "reset");
        rstn = 1'b1;
        cyc(4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, "idle");
        cyc(4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, "idle");

        // ch0 default D=5 (11100), then a D=4 write at cnt=2 applies at the next wrap.
        for (int k = 0; k < 20; k++)
            cyc(4'b0001, k == 18, 0, 16'd4, 0, {3'b000, k == 18 || k == 19},
                {3'b000, (k % 5) == 0}, {3'b000, (k % 5) < 3}, k < 18 ? "d5_run" : "d4_pending");
        for (int m = 0; m < 12; m++)
            cyc(4'b0001, 0, 0, 0, 0, 4'h0, {3'b000, (m % 4) == 0}, {3'b000, (m % 4) < 2}, "d4_run");

        // Rejected writes: zero divisor, then channel 3 on the 3-channel instance.
        cyc(4'b0001, 1, 0, 16'd0, 1, 4'h0, 4'b0001, 4'b0001, "err_div0");
        cyc(4'b0001, 0, 3, 16'd5, 0, 4'h0, 4'b0000, 4'b0001, "err_ch_range", 1'b1, 1'b1);
        // D=1 on idle ch1 applies at once, then runs constantly high.
        cyc(4'b0001, 1, 1, 16'd1, 0, 4'b0010, 4'b0000, 4'b0000, "d1_write");
        cyc(4'b0001, 0, 0, 0, 0, 4'h0, 4'b0000, 4'b0000, "d1_idle_apply");
        for (int m = 0; m < 8; m++)
            cyc(4'b0011, 0, 0, 0, 0, 4'h0, {2'b00, 1'b1, (m % 4) == 0}, {2'b00, 1'b1, (m % 4) < 2}, "d1_run");
        cyc(4'b0001, 0, 0, 0, 0, 4'h0, 4'b0001, 4'b0001, "d1_stop");

        // ch2 disabled during its high phase, reprogrammed to D=3 while idle, re-enabled.
        cyc(4'b0100, 0, 0, 0, 0, 4'h0, 4'b0100, 4'b0100, "ch2_start");
        cyc(4'b0100, 0, 0, 0, 0, 4'h0, 4'b0000, 4'b0100, "ch2_high");
        cyc(4'b0000, 0, 0, 0, 0, 4'h0, 4'b0000, 4'b0000, "ch2_truncate");
        cyc(4'b0000, 1, 2, 16'd3, 0, 4'b0100, 4'b0000, 4'b0000, "ch2_write_idle");
        cyc(4'b0000, 0, 0, 0, 0, 4'h0, 4'b0000, 4'b0000, "ch2_idle_apply");
        for (int n = 0; n < 9; n++)
            cyc(4'b0100, 0, 0, 0, 0, 4'h0, {1'b0, (n % 3) == 0, 2'b00}, {1'b0, (n % 3) < 2, 2'b00}, "d3_run");

        // Reset while ch0 is high with a pending write; restart uses the default D=5.
        cyc(4'b0001, 0, 0, 0, 0, 4'h0, 4'b0001, 4'b0001, "pre_reset_wrap");
        cyc(4'b0001, 1, 0, 16'd7, 0, 4'b0001, 4'b0000, 4'b0001, "pre_reset_pend");
        rst_now();
        cyc(4'b0001, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, "in_reset");
        cyc(4'b0001, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, "in_reset");
        rstn = 1'b1;
        for (int k = 0; k < 10; k++)
            cyc(4'b0001, 0, 0, 0, 0, 4'h0, {3'b000, (k % 5) == 0}, {3'b000, (k % 5) < 3}, "post_reset_d5");

`ifdef CLOCK_DIV_SYNC_EN
        // ch1 at D=10 started out of phase with ch0, then a sync pulse aligns them.
        cyc(4'b0001, 1, 1, 16'd10, 0, 4'b0010, 4'b0001, 4'b0001, "sync_setup");
        cyc(4'b0001, 0, 0, 0, 0, 4'h0, 4'b0000, 4'b0001, "sync_setup");
        for (int c = 0; c < 5; c++)
            cyc(4'b0011, 0, 0, 0, 0, 4'h0, {2'b00, c == 0, ((c + 2) % 5) == 0},
                {2'b00, 1'b1, ((c + 2) % 5) < 3}, "pre_sync");
        for (int t = 0; t < 20; t++) begin
            sync_in = (t == 0);
            cyc(4'b0011, 0, 0, 0, 0, 4'h0, {2'b00, (t % 10) == 0, (t % 5) == 0},
                {2'b00, (t % 10) < 5, (t % 5) < 3}, "post_sync");
        end
        sync_in = 1'b0;
`endif

        cfg_wr = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clksrc);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors never compared, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200_000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

endmodule
